// File: rtl/collision_detect.sv
// collision_detect: per-pixel duck/obstacle overlap monitor for the
// ducking-duck game. Counts lit-on-lit pixels inside the visible area in
// each frame, and raises a debounced, level-held hit flag once enough
// consecutive frames qualify. The game FSM clears the flag with hit_ack.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | game not running; hit low, streak and accumulator held at 0
// ST_ARMED | game running; each frame end scores the frame into the streak
// ST_HIT   | hit high; frame scoring suspended until hit_ack
module collision_detect #(
  parameter int CIDXW      = 3,
  parameter int CORDW      = 10,
  parameter int HIT_PIX    = 4,
  parameter int HIT_FRAMES = 2
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [3:0]       state,
  input  logic [CORDW-1:0] hc,
  input  logic [CORDW-1:0] vc,
  input  logic [CIDXW:0]   duck_pix,
  input  logic [CIDXW:0]   obstacle_pix,
  input  logic             hit_ack,
  output logic             hit,
  output logic [7:0]       overlap_count,
  output logic             frame_done
);

  // Visible window in aligned scan coordinates
  localparam logic [CORDW-1:0] H_LO = CORDW'(143);
  localparam logic [CORDW-1:0] H_HI = CORDW'(784);
  localparam logic [CORDW-1:0] V_LO = CORDW'(34);
  localparam logic [CORDW-1:0] V_HI = CORDW'(516);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_HIT   = 2'd2
  } fsm_t;

  // Scan-coordinate delay line; the pixel streams arrive two cycles late
  logic [CORDW-1:0] hc_p_q, hc_p_d, vc_p_q, vc_p_d;
  logic [CORDW-1:0] hc_a_q, hc_a_d, vc_a_q, vc_a_d;
  // Fill tracker: the zeroed pipeline after reset must not look like (0,0)
  logic [1:0]       vld_q, vld_d;

  fsm_t             fsm_q, fsm_d;
  logic             hit_q, hit_d;
  logic [3:0]       streak_q, streak_d;
  logic [7:0]       acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             fd_q, fd_d;

  logic             running;
  logic             in_win;
  logic             both_lit;
  logic             overlap;
  logic             frame_end;
  logic             frame_ok;
  logic [7:0]       acc_inc;
  logic [3:0]       streak_inc;

  // Next values of the coordinate delay line
  always_comb begin
    hc_p_d = hc;
    vc_p_d = vc;
    hc_a_d = hc_p_q;
    vc_a_d = vc_p_q;
    vld_d  = {vld_q[0], 1'b1};
  end

  // Coordinate delay line registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hc_p_q <= '0;
      vc_p_q <= '0;
      hc_a_q <= '0;
      vc_a_q <= '0;
      vld_q  <= '0;
    end else begin
      hc_p_q <= hc_p_d;
      vc_p_q <= vc_p_d;
      hc_a_q <= hc_a_d;
      vc_a_q <= vc_a_d;
      vld_q  <= vld_d;
    end
  end

  assign running    = (state >= 4'd5) && (state <= 4'd10);
  assign in_win     = (hc_a_q >= H_LO) && (hc_a_q <= H_HI) &&
                      (vc_a_q >= V_LO) && (vc_a_q <= V_HI);
  assign both_lit   = (|duck_pix) && (|obstacle_pix);
  assign overlap    = running && in_win && both_lit;
  assign frame_end  = vld_q[1] && (hc_a_q == '0) && (vc_a_q == '0);
  assign acc_inc    = (overlap && (acc_q != 8'hFF)) ? acc_q + 8'd1 : acc_q;
  assign frame_ok   = acc_q >= 8'(HIT_PIX);
  assign streak_inc = streak_q + 4'd1;

  // Next-state, streak, accumulator and reporting logic
  always_comb begin
    fsm_d    = fsm_q;
    hit_d    = hit_q;
    streak_d = streak_q;
    acc_d    = frame_end ? 8'd0 : acc_inc;
    cnt_d    = frame_end ? acc_q : cnt_q;
    fd_d     = frame_end;
    case (fsm_q)
      ST_IDLE: begin
        hit_d    = 1'b0;
        streak_d = 4'd0;
        if (running) begin
          // Partial frame from here on counts toward the first frame end
          fsm_d = ST_ARMED;
        end else begin
          acc_d = 8'd0;
        end
      end
      ST_ARMED: begin
        if (!running) begin
          fsm_d    = ST_IDLE;
          streak_d = 4'd0;
          acc_d    = 8'd0;
        end else if (frame_end) begin
          if (frame_ok) begin
            if (streak_inc == 4'(HIT_FRAMES)) begin
              fsm_d    = ST_HIT;
              hit_d    = 1'b1;
              streak_d = 4'd0;
            end else begin
              streak_d = streak_inc;
            end
          end else begin
            streak_d = 4'd0;
          end
        end
      end
      ST_HIT: begin
        hit_d = 1'b1;
        // Ack beats a coincident frame end; that frame is dropped
        if (hit_ack) begin
          hit_d    = 1'b0;
          streak_d = 4'd0;
          acc_d    = 8'd0;
          fsm_d    = running ? ST_ARMED : ST_IDLE;
        end
      end
      default: begin
        fsm_d    = ST_IDLE;
        hit_d    = 1'b0;
        streak_d = 4'd0;
        acc_d    = 8'd0;
      end
    endcase
  end

  // FSM and registered outputs
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fsm_q    <= ST_IDLE;
      hit_q    <= 1'b0;
      streak_q <= 4'd0;
      acc_q    <= 8'd0;
      cnt_q    <= 8'd0;
      fd_q     <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      hit_q    <= hit_d;
      streak_q <= streak_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      fd_q     <= fd_d;
    end
  end

  assign hit           = hit_q;
  assign overlap_count = cnt_q;
  assign frame_done    = fd_q;

endmodule
